uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Receive-side UART core with an integrated receive FIFO: the counterpart of the transmit core on the same serial link. It oversamples the asynchronous `rx` line at 16x baud, frames 8N1 characters (optional even parity), and buffers received bytes in a show-ahead FIFO. Host logic drains the FIFO with the same toggle handshake the transmit core uses for `start_transmission`.

## Interface
- `TICK_DIVISOR`, 54: clk cycles per 16x oversample tick (100 MHz / (115200 × 16)); legal range ≥ 1.
- `FIFO_ADDR_WIDTH`, 4: FIFO depth = 2^FIFO_ADDR_WIDTH entries (16).

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `read_request`  in  1  toggle; each transition pops one byte.
- `data_out`  out  8  FIFO head byte; valid while `data_available`=1.
- `data_available`  out  1  FIFO not empty.
- `fifo_full`  out  1  FIFO holds 2^FIFO_ADDR_WIDTH bytes.
- `busy`  out  1  a frame is being received (start validated through stop sample).
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_error`  out  1  one-cycle pulse: byte completed while FIFO full.
- `parity_error`  out  1  one-cycle pulse: parity mismatch (0 when parity compiled out).

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- Tick generator: counter 0..TICK_DIVISOR-1. It emits a one-cycle `tick` on wrap and runs continuously.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP. A 4-bit tick counter `s` and a 3-bit bit counter `n` drive the transitions.
  - IDLE: when `rx_s`=0, go to START with `s`=0.
  - START: on the tick where `s`=7, sample `rx_s`. If it is 1 (glitch), return to IDLE with no flags. If it is 0, go to DATA with `s`=0 and `n`=0, and raise `busy`.
  - DATA: on the tick where `s`=15, shift `rx_s` into bit 7 of the shift register (LSB-first reception). Leave after `n`=7.
  - PARITY: on the tick where `s`=15, sample the parity bit.
  - STOP: on the tick where `s`=15, sample the stop bit, then return to IDLE.
- At stop sample:
  - Stop bit low: pulse `framing_error` and discard the byte.
  - Parity mismatch: pulse `parity_error` and discard the byte.
  - Otherwise, if `fifo_full`=1, pulse `overrun_error` and drop the new byte; FIFO contents are unchanged.
  - Otherwise push the byte.
- Read handshake:
  - `read_request` is registered. Its XOR with the previous value gives a one-cycle pop pulse.
  - A pop on an empty FIFO is ignored (no pointer change, no error).
- FIFO:
  - Binary read/write pointers with an extra wrap bit. Full and empty are derived from pointer compare.
  - Simultaneous push and pop is legal even when full or empty: a push at full with a pop in the same cycle is accepted.
  - Pointers wrap modulo 2^(FIFO_ADDR_WIDTH+1).
- Reset state: FSM in IDLE, all counters and pointers at 0, shift register 0.
  - Outputs: `data_out`=0, `data_available`=0, `fifo_full`=0, `busy`=0, all error pulses 0.
  - Reset mid-frame abandons the frame; reception resumes at the next falling edge after reset release.

## Timing
- `rx` to `rx_s`: 2 clk.
- One bit period = 16 × TICK_DIVISOR clk. Bits are sampled at mid-bit, 8 ticks after the detected edge plus a multiple of 16 ticks.
- Push occurs on the clk edge after the stop-sample tick. `data_available` rises 1 clk after the push; `data_out` is valid in the same cycle.
- `busy` falls on the same edge as the push or error pulse.
- Pop: `read_request` toggles at edge T. The pop pulse is at T+1; `data_out` and `data_available` update at T+2.
- Error pulses are exactly 1 clk wide.
- The FSM can detect the next start 1 clk after leaving STOP, so back-to-back frames with one stop bit are supported.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is start + 8 data + even parity + stop. The PARITY state is compiled in, and `parity_error` pulses on mismatch.
- `UART_RX_PARITY_EN` undefined: 8N1 only. The PARITY state is absent and `parity_error` is tied to 0.

## Test plan
Use `TICK_DIVISOR`=2, so one bit = 32 clk.
- Release reset, drive frame 0x0A on `rx`, 8N1. Expect `busy` high during the frame, then `data_available`=1 and `data_out`=0x0A. Toggle `read_request`; 2 clk later `data_available`=0.
- Send 0x0D and 0x0E back-to-back. Expect two pushes, in order, with no errors. Both bytes are drained correctly by two toggles.
- Drive a 3×TICK_DIVISOR-clk low glitch on an idle line. Expect FSM back in IDLE, no push, `busy` never set.
- Send 0x55 with stop bit forced low. Expect one `framing_error` pulse and FIFO count unchanged.
- Send 17 bytes 0x00..0x10 without reading. Expect `fifo_full`=1 after 16 bytes, one `overrun_error` pulse, and a drain yielding 0x00..0x0F.
- With `UART_RX_PARITY_EN`: send 0x03 with parity bit 1. Expect `parity_error` pulse and no push. Send it with parity bit 0: expect a push of 0x03.
- Assert `reset` during DATA of frame 0xA5. Expect all outputs at reset values. A following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled 8N1 framing into a show-ahead receive FIFO.
// Optional even parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int TICK_DIVISOR    = 54,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       read_request,
  output logic [7:0] data_out,
  output logic       data_available,
  output logic       fifo_full,
  output logic       busy,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       parity_error,
  output logic [2:0] state_dbg
);

  localparam int TW    = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int PW    = FIFO_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  logic          sync_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_e        state_q, state_d;
  logic [3:0]    s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;
  logic          req_q, req_prev_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          empty, full, pop;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  assign tick  = (tick_cnt_q == TW'(TICK_DIVISOR - 1));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  // Read handshake: every level change of read_request is one pop request;
  // a request while the FIFO is empty is dropped.
  assign pop   = (req_q ^ req_prev_q) && !empty;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    ferr_d      = 1'b0;
    oerr_d      = 1'b0;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    perr_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          s_d     = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd7) begin
            s_d = 4'd0;
            n_d = 3'd0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd15) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            n_d     = n_q + 3'd1;
            if (n_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd15) begin
            par_d   = rx_s_q;
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd15) begin
            state_d = S_IDLE;
            if (!rx_s_q) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if ((^shreg_q) != par_q) begin
              perr_d = 1'b1;
`endif
            // A pop in this same cycle frees the slot the new byte needs.
            end else if (full && !pop) begin
              oerr_d = 1'b1;
            end else begin
              push_d      = 1'b1;
              push_byte_d = shreg_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push_q ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      state_q     <= S_IDLE;
      s_q         <= 4'd0;
      n_q         <= 3'd0;
      shreg_q     <= 8'h00;
      push_q      <= 1'b0;
      push_byte_q <= 8'h00;
      ferr_q      <= 1'b0;
      oerr_q      <= 1'b0;
      req_q       <= 1'b0;
      req_prev_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      sync_q      <= rx;
      rx_s_q      <= sync_q;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      ferr_q      <= ferr_d;
      oerr_q      <= oerr_d;
      req_q       <= read_request;
      req_prev_q  <= req_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_q      <= perr_d;
`endif
    end
  end

  // Storage needs no reset: data_out is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_q) mem_q[wr_ptr_q[PW-2:0]] <= push_byte_q;
  end

  always_comb begin
    data_out       = empty ? 8'h00 : mem_q[rd_ptr_q[PW-2:0]];
    data_available = !empty;
    fifo_full      = full;
    framing_error  = ferr_q;
    overrun_error  = oerr_q;
    state_dbg      = state_q;
    busy           = (state_q == S_DATA) || (state_q == S_STOP);
`ifdef UART_RX_PARITY_EN
    busy           = busy || (state_q == S_PARITY);
    parity_error   = perr_q;
`else
    parity_error   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: a queue-based model of the receive FIFO
// predicts read data and error pulses; a monitor checks pulses as they occur.
module tb_uart_rx_core;

  localparam int TD    = 2;
  localparam int BIT   = 16 * TD;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       read_request;
  logic [7:0] data_out;
  logic       data_available, fifo_full, busy;
  logic       framing_error, overrun_error, parity_error;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  uart_rx_core #(.TICK_DIVISOR(TD), .FIFO_ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .read_request   (read_request),
    .data_out       (data_out),
    .data_available (data_available),
    .fifo_full      (fifo_full),
    .busy           (busy),
    .framing_error  (framing_error),
    .overrun_error  (overrun_error),
    .parity_error   (parity_error),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  int         busy_cnt = 0;
  logic [7:0] exp_q[$];     // reference FIFO contents, head first
  int         err_exp_q[$]; // expected error pulses: 4=framing 2=overrun 1=parity

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (reset && (framing_error || overrun_error || parity_error)) begin
      if (err_exp_q.size() == 0)
        check("unexpected_err_pulse", {29'd0, framing_error, overrun_error, parity_error}, 32'd0);
      else
        check("err_pulse", {29'd0, framing_error, overrun_error, parity_error}, err_exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model applied at frame level, then the line is driven.
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b);
    if (!stop_b) err_exp_q.push_back(4);
    else if (PAR_ON && (par_b != ^d)) err_exp_q.push_back(1);
    else if (exp_q.size() == DEPTH) err_exp_q.push_back(2);
    else exp_q.push_back(d);
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT);
    end
    if (PAR_ON) begin
      rx = par_b;
      step(BIT);
    end
    if (stop_b) begin
      rx = 1'b1;
      step(BIT);
    end else begin
      rx = 1'b0;
      step(20);
      rx = 1'b1;
      step(40);
    end
  endtask

  task automatic send_ok(input logic [7:0] d);
    send(d, 1'b1, ^d);
  endtask

  task automatic read_one();
    if (exp_q.size() == 0) begin
      check("read_with_empty_model", {31'd0, data_available}, 32'd0);
    end else begin
      check("data_available_before_pop", {31'd0, data_available}, 32'd1);
      check("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      read_request = ~read_request;
      step(2);
    end
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) read_one();
    check("empty_after_drain", {31'd0, data_available}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    check({tag, "_data_available"}, {31'd0, data_available}, 32'd0);
    check({tag, "_fifo_full"}, {31'd0, fifo_full}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_errors"}, {29'd0, framing_error, overrun_error, parity_error}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int b0;
    logic [7:0] d;
    reset = 1'b0;
    rx = 1'b1;
    read_request = 1'b0;
    step(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    step(5);

    // single frame, busy and pop latency
    b0 = busy_cnt;
    send_ok(8'h0A);
    check("busy_during_frame", {31'd0, (busy_cnt - b0) >= 8 * BIT}, 32'd1);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    read_one();
    check("data_available_2clk_after_pop", {31'd0, data_available}, 32'd0);

    // back-to-back frames
    send_ok(8'h0D);
    send_ok(8'h0E);
    drain_all();

    // short low glitch on idle line
    b0 = busy_cnt;
    rx = 1'b0;
    step(3 * TD);
    rx = 1'b1;
    step(60);
    check("glitch_busy_never", busy_cnt - b0, 32'd0);
    check("glitch_state_idle", {29'd0, state_dbg}, 32'd0);
    check("glitch_no_push", {31'd0, data_available}, 32'd0);

    // framing error
    send(8'h55, 1'b0, ^8'h55);
    check("framing_no_push", {31'd0, data_available}, 32'd0);
    check("framing_state_idle", {29'd0, state_dbg}, 32'd0);

    // fill, overrun, drain
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_ok(8'(i));
      if (i == DEPTH - 2) check("full_at_15", {31'd0, fifo_full}, 32'd0);
      if (i == DEPTH - 1) check("full_at_16", {31'd0, fifo_full}, 32'd1);
    end
    check("full_after_overrun", {31'd0, fifo_full}, 32'd1);
    drain_all();
    check("not_full_after_drain", {31'd0, fifo_full}, 32'd0);

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1, 1'b1);
    check("parity_bad_no_push", {31'd0, data_available}, 32'd0);
    send(8'h03, 1'b1, 1'b0);
    drain_all();
`endif

    // randomized traffic
    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom_range(0, 255));
      send(d, $urandom_range(0, 7) != 0, (^d) ^ ($urandom_range(0, 7) == 0));
      step($urandom_range(0, 20));
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) read_one();
    end
    drain_all();

    // reset in the middle of a frame
    send_ok(8'h77);
    d = 8'hA5;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      step(BIT);
    end
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    step(2);
    check_reset_outputs("midframe_reset");
    reset = 1'b1;
    step(5);
    send_ok(8'h3C);
    drain_all();

    step(20);
    check("no_missing_err_pulses", err_exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
